sisc_fetch_unit: RTL

//   Parametrised instruction fetch stage for the SISC core; replaces the separate pc/br/ir trio.

---
 rtl/sisc_fetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sisc_fetch_unit.sv
//==============================================================================
// Module      : sisc_fetch_unit
// Description : Instruction fetch stage for the SISC core. Holds the fetch PC,
//               addresses a combinational instruction memory every cycle,
//               buffers fetched words in a DEPTH-entry prefetch queue and
//               presents the queue head to ctrl with a valid/ready handshake.
//               Taken branches flush the queue and redirect the fetch PC.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   AW       - instruction address width; the PC wraps modulo 2^AW
//   IW       - instruction word width
//   DEPTH    - prefetch queue entries (power of 2, >= 2)
//   RESET_PC - fetch PC loaded on reset
// Ports:
//   clk         in   rising-edge clock
//   rst_f       in   asynchronous active-low reset
//   fetch_en    in   fetch allowed this cycle (queue drains regardless)
//   im_addr     out  instruction memory address (= fetch PC)
//   im_data     in   instruction memory read data
//   instr       out  queue head instruction, 0 when queue empty
//   instr_pc    out  address of instr, holds last value when queue empty
//   instr_valid out  queue non-empty
//   instr_ready in   ctrl consumes head when instr_valid && instr_ready
//   br_taken    in   redirect fetch at this edge
//   br_rel      in   relative target select (SISC_FETCH_REL_BR_EN only)
//   br_imm      in   absolute target or signed relative offset
//   q_count     out  entries currently queued
// Configuration:
//   SISC_FETCH_REL_BR_EN - when defined, br_rel selects a PC-relative target
//                          (instr_pc + 1 + br_imm); otherwise every branch is
//                          absolute and no relative adder is built.
//==============================================================================
`default_nettype none

module sisc_fetch_unit #(
  parameter int          AW       = 16,
  parameter int          IW       = 32,
  parameter int          DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_f,
  input  logic                       fetch_en,
  output logic [AW-1:0]              im_addr,
  input  logic [IW-1:0]              im_data,
  output logic [IW-1:0]              instr,
  output logic [AW-1:0]              instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  input  logic                       br_taken,
  input  logic                       br_rel,
  input  logic [AW-1:0]              br_imm,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [AW-1:0]   r_fetch_pc;
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;
  logic [AW-1:0]   r_hold_pc;
  logic [IW-1:0]   r_q_data [DEPTH];
  logic [AW-1:0]   r_q_pc   [DEPTH];

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [AW-1:0]   w_target;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & instr_ready;
  // A full queue can still accept a word when the head leaves on the same edge.
  assign w_push  = fetch_en & ~br_taken & ((r_count < c_CW'(DEPTH)) | w_pop);

`ifdef SISC_FETCH_REL_BR_EN
  assign w_target = br_rel ? (instr_pc + AW'(1) + br_imm) : br_imm;
`else
  logic w_unused_br_rel;
  assign w_unused_br_rel = br_rel;
  assign w_target        = br_imm;
`endif

  assign im_addr     = r_fetch_pc;
  assign instr_valid = w_valid;
  assign q_count     = r_count;
  assign instr       = w_valid ? r_q_data[r_head] : '0;
  // When empty, keep showing the address of the last head that was presented.
  assign instr_pc    = w_valid ? r_q_pc[r_head] : r_hold_pc;

  // Queue storage carries no reset: entries are only ever read while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_tail] <= im_data;
      r_q_pc[r_tail]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_hold_pc  <= '0;
    end else begin
      if (w_valid) begin
        r_hold_pc <= r_q_pc[r_head];
      end
      if (br_taken) begin
        // Flush wins over any simultaneous pop; a popped head is still consumed by ctrl.
        r_fetch_pc <= w_target;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
      end else begin
        if (w_push) begin
          r_tail     <= r_tail + c_PW'(1);
          r_fetch_pc <= r_fetch_pc + AW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + c_PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CW'(1);
          2'b01:   r_count <= r_count - c_CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
